// File: rtl/dout_history_display.sv
// dout_history_display
//   Receiving end of the CPU's Dout/Dval output port. Every rising edge of
//   Dval captures Dout into a DEPTH-entry circular history. Two debounced,
//   active-low push-buttons browse older captures (prev) and step back
//   towards live view (next). The viewed entry, its age, the entry count and
//   the view mode are shown on the HEX displays; LEDR shows the newest byte,
//   the sticky overflow flag and a capture toggle.
//
// Ports
//   clk        system clock, rising edge
//   Reset      asynchronous active-low reset
//   Dout[7:0]  CPU output data
//   Dval       CPU output valid (level; a capture happens on its rising edge)
//   Btn_prev   raw KEY, active-low: step to an older entry
//   Btn_next   raw KEY, active-low: step to a newer entry / back to live
//   HEX0..HEX5 active-low 7-segment outputs, bit order {g,f,e,d,c,b,a}
//   LEDR[9:0]  [7:0] newest entry, [8] overflow, [9] toggles per capture

// Synchroniser + debouncer for one active-low button; emits a single-cycle
// pulse when a press (accepted 1->0 transition) is recognised.
module dhd_debounce #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic Reset,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [1:0]    sync;
  logic          accepted;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      sync     <= 2'b11;
      accepted <= 1'b1;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      sync  <= {sync[0], btn};
      press <= 1'b0;
      if (sync[1] != accepted) begin
        if (cnt == CW'(DEB_CYCLES - 1)) begin
          accepted <= sync[1];
          cnt      <= '0;
          press    <= ~sync[1];
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

module dout_history_display #(
  parameter int DEPTH      = 8,
  parameter int DEB_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic [7:0] Dout,
  input  logic       Dval,
  input  logic       Btn_prev,
  input  logic       Btn_next,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic [9:0] LEDR
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {LIVE, BROWSE} view_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [3:0]    count, count_n;
  logic [2:0]    offset, off_c;
  logic          ovf, tgl, dval_q;
  view_t         state;
  logic          prev_p, next_p, capture;
  logic [AW-1:0] view_idx, new_idx;
  logic [3:0]    off_inc;

  dhd_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_prev (
    .clk(clk), .Reset(Reset), .btn(Btn_prev), .press(prev_p));
  dhd_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_next (
    .clk(clk), .Reset(Reset), .btn(Btn_next), .press(next_p));

  assign capture = Dval & ~dval_q;

  // Capture adjustments come first; button handling then works on these.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    count_n = count;
    off_c   = offset;
    if (capture) begin
      if (count != 4'(DEPTH)) count_n = count + 4'd1;
      if (state == BROWSE && {1'b0, offset} != 4'(DEPTH - 1))
        off_c = offset + 3'd1;
    end
    off_inc = {1'b0, off_c} + 4'd1;
    if (off_inc > count_n - 4'd1) off_inc = count_n - 4'd1;
  end

  // NOTE: the history array carries no reset; nothing reads an entry before
  // it has been written (count gates every read), so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (capture) mem[wr_ptr] <= Dout;
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr <= '0;
      count  <= '0;
      offset <= '0;
      ovf    <= 1'b0;
      tgl    <= 1'b0;
      dval_q <= 1'b0;
      state  <= LIVE;
    end else begin
      dval_q <= Dval;
      count  <= count_n;
      if (capture) begin
        wr_ptr <= wr_ptr + 1'b1;
        tgl    <= ~tgl;
        if (count == 4'(DEPTH)) ovf <= 1'b1;
      end
      case (state)
        LIVE: begin
          offset <= '0;
          if (prev_p && !next_p && count_n >= 4'd2) begin
            state  <= BROWSE;
            offset <= 3'd1;
          end
        end
        BROWSE: begin
          offset <= off_c;
          if (prev_p && !next_p) begin
            offset <= off_inc[2:0];
          end else if (next_p && !prev_p) begin
            if (off_c > 3'd1) begin
              offset <= off_c - 3'd1;
            end else begin
              state  <= LIVE;
              offset <= '0;
            end
          end
        end
        default: state <= LIVE;
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h40; 4'h1: seg7 = 7'h79; 4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30; 4'h4: seg7 = 7'h19; 4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02; 4'h7: seg7 = 7'h78; 4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10; 4'hA: seg7 = 7'h08; 4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46; 4'hD: seg7 = 7'h21; 4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  // Age a lives at wr_ptr-1-a (mod DEPTH).
  assign new_idx  = wr_ptr - AW'(1);
  assign view_idx = new_idx - offset[AW-1:0];

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      HEX0 <= 7'h3F;
      HEX1 <= 7'h3F;
      HEX2 <= 7'h7F;
      HEX3 <= 7'h40;
      HEX4 <= 7'h40;
      HEX5 <= 7'h47;
      LEDR <= '0;
    end else begin
      HEX0 <= (count == 4'd0) ? 7'h3F : seg7(mem[view_idx][3:0]);
      HEX1 <= (count == 4'd0) ? 7'h3F : seg7(mem[view_idx][7:4]);
      HEX2 <= 7'h7F;
      HEX3 <= seg7({1'b0, offset});
      HEX4 <= seg7(count);
      HEX5 <= (state == LIVE) ? 7'h47 : 7'h03;
      LEDR <= {tgl, ovf, (count == 4'd0) ? 8'h00 : mem[new_idx]};
    end
  end
endmodule

// File: tb/tb_dout_history_display.sv
module tb_dout_history_display;
  logic       clk = 1'b0;
  logic       Reset;
  logic [7:0] Dout;
  logic       Dval;
  logic       Btn_prev, Btn_next;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [9:0] LEDR;

  int n_tests = 0;
  int n_fail  = 0;

  dout_history_display #(.DEPTH(8), .DEB_CYCLES(4)) dut (
    .clk(clk), .Reset(Reset), .Dout(Dout), .Dval(Dval),
    .Btn_prev(Btn_prev), .Btn_next(Btn_next),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4),
    .HEX5(HEX5), .LEDR(LEDR));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [9:0] got,
                       input logic [9:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic capture(input logic [7:0] d, input int hold);
    @(negedge clk);
    Dout = d;
    Dval = 1'b1;
    repeat (hold) @(negedge clk);
    Dval = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic press(input logic p, input logic n, input int hold);
    @(negedge clk);
    Btn_prev = ~p;
    Btn_next = ~n;
    repeat (hold) @(negedge clk);
    Btn_prev = 1'b1;
    Btn_next = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    Reset = 1'b0;
    repeat (2) @(negedge clk);
    Reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hex0"}, 10'(HEX0), 10'h3F);
    check({tag, "_hex1"}, 10'(HEX1), 10'h3F);
    check({tag, "_hex2"}, 10'(HEX2), 10'h7F);
    check({tag, "_hex3"}, 10'(HEX3), 10'h40);
    check({tag, "_hex4"}, 10'(HEX4), 10'h40);
    check({tag, "_hex5"}, 10'(HEX5), 10'h47);
    check({tag, "_ledr"}, LEDR, 10'h000);
  endtask

  initial begin
    Reset = 1'b0; Dout = 8'h00; Dval = 1'b0; Btn_prev = 1'b1; Btn_next = 1'b1;
    repeat (3) @(negedge clk);
    Reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");

    // Single capture with Dval held for three cycles.
    capture(8'hA5, 3);
    check("a5_hex1", 10'(HEX1), 10'h08);
    check("a5_hex0", 10'(HEX0), 10'h12);
    check("a5_hex4", 10'(HEX4), 10'h79);
    check("a5_ledr", LEDR, 10'h2A5);

    // Overflow: 11 captures total, toggle ends at 1.
    for (int i = 0; i < 10; i++) capture(8'(i), 1);
    check("ovf_hex4", 10'(HEX4), 10'h00);
    check("ovf_ledr", LEDR, 10'h309);
    for (int i = 0; i < 7; i++) press(1'b1, 1'b0, 6);
    check("age7_hex3", 10'(HEX3), 10'h78);
    check("age7_hex1", 10'(HEX1), 10'h40);
    check("age7_hex0", 10'(HEX0), 10'h24);
    press(1'b1, 1'b0, 6);
    check("age7sat_hex3", 10'(HEX3), 10'h78);
    check("age7sat_hex0", 10'(HEX0), 10'h24);
    check("age7sat_hex5", 10'(HEX5), 10'h03);

    // Debounce filtering and browse-follow on capture.
    do_reset();
    capture(8'h11, 1); capture(8'h22, 1); capture(8'h33, 1);
    press(1'b1, 1'b0, 2);
    check("short_hex5", 10'(HEX5), 10'h47);
    check("short_hex0", 10'(HEX0), 10'h30);
    press(1'b1, 1'b0, 6);
    check("long_hex5", 10'(HEX5), 10'h03);
    check("long_hex1", 10'(HEX1), 10'h24);
    check("long_hex3", 10'(HEX3), 10'h79);
    capture(8'h44, 1);
    check("follow_hex0", 10'(HEX0), 10'h24);
    check("follow_hex3", 10'(HEX3), 10'h24);
    check("follow_hex4", 10'(HEX4), 10'h19);
    check("follow_ledr", LEDR, 10'h044);

    // Step back to live, then a simultaneous press does nothing.
    press(1'b0, 1'b1, 6);
    check("next1_hex3", 10'(HEX3), 10'h79);
    check("next1_hex0", 10'(HEX0), 10'h30);
    press(1'b0, 1'b1, 6);
    check("live_hex5", 10'(HEX5), 10'h47);
    check("live_hex0", 10'(HEX0), 10'h19);
    check("live_hex3", 10'(HEX3), 10'h40);
    press(1'b1, 1'b1, 6);
    check("both_hex5", 10'(HEX5), 10'h47);
    check("both_hex3", 10'(HEX3), 10'h40);

    // Reset with a press half-debounced while browsing.
    press(1'b1, 1'b0, 6);
    check("pre_rst_hex5", 10'(HEX5), 10'h03);
    @(negedge clk);
    Btn_prev = 1'b0;
    repeat (3) @(negedge clk);
    Reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    Reset = 1'b1;
    repeat (12) @(negedge clk);
    check("postrst_hex5", 10'(HEX5), 10'h47);
    check("postrst_hex3", 10'(HEX3), 10'h40);
    check("postrst_hex4", 10'(HEX4), 10'h40);
    Btn_prev = 1'b1;
    repeat (10) @(negedge clk);
    capture(8'h5A, 1);
    capture(8'hC3, 1);
    check("postrst_cap_hex5", 10'(HEX5), 10'h47);
    check("postrst_cap_hex1", 10'(HEX1), 10'h46);
    check("postrst_cap_ledr", LEDR, 10'h0C3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
